// File: rtl/gravador_notas_if.sv
// Song-memory write bus driven by the note recorder.
// Address, data and strobe share one bundle so the memory side sees a single port.
interface gravador_notas_if #(
  parameter int ADDR_W = 6,
  parameter int DUR_W  = 4
);
  logic [ADDR_W-1:0]  mem_endereco;
  logic [4+DUR_W-1:0] mem_dado;
  logic               mem_we;

  modport master (output mem_endereco, mem_dado, mem_we);
  modport slave  (input  mem_endereco, mem_dado, mem_we);
endinterface

// File: rtl/gravador_notas.sv
// Note recorder: captures held keys, times them in metronome ticks and writes
// {code, duration} words to song memory, closing every recording with a zero marker.
module gravador_notas #(
  parameter int ADDR_W = 6,
  parameter int DUR_W  = 4,
  parameter int TECLAS = 12
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar_gravacao,
  input  logic              parar,
  input  logic [TECLAS-1:0] teclas,
  input  logic              tick_metro,
  gravador_notas_if.master  mem,
  output logic              gravando,
  output logic              memoria_cheia,
  output logic              fim_gravacao,
  output logic [3:0]        db_estado
);

  typedef enum logic [3:0] {
    OCIOSO      = 4'd0,
    PREPARA     = 4'd1,
    ESPERA_NOTA = 4'd2,
    SEGURA      = 4'd3,
    GRAVA       = 4'd4,
    PROXIMO     = 4'd5,
    ESCREVE_FIM = 4'd6,
    FIM         = 4'd7
  } estado_t;

  localparam logic [ADDR_W-1:0] END_ULTIMO = '1;

  estado_t            estado;
  logic [ADDR_W-1:0]  endereco;
  logic [DUR_W-1:0]   duracao;
  logic [3:0]         codigo;
  logic               parar_lat;
  logic               mem_we_r;
  logic [4+DUR_W-1:0] mem_dado_r;
  logic [DUR_W-1:0]   dur_sat;

  // Lowest pressed key wins; code 0 is reserved for "no key".
  function automatic logic [3:0] codigo_de(input logic [TECLAS-1:0] t);
    codigo_de = '0;
    for (int i = TECLAS-1; i >= 0; i--)
      if (t[i]) codigo_de = 4'(i + 1);
  endfunction

  // Duration including this cycle's tick, so a tick on the release cycle still counts.
  assign dur_sat = (tick_metro && duracao != '1) ? duracao + DUR_W'(1) : duracao;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado        <= OCIOSO;
      endereco      <= '0;
      duracao       <= '0;
      codigo        <= '0;
      parar_lat     <= 1'b0;
      mem_we_r      <= 1'b0;
      mem_dado_r    <= '0;
      gravando      <= 1'b0;
      memoria_cheia <= 1'b0;
      fim_gravacao  <= 1'b0;
    end else begin
      mem_we_r <= 1'b0;
      case (estado)
        OCIOSO: if (iniciar_gravacao) begin
          estado        <= PREPARA;
          gravando      <= 1'b1;
          memoria_cheia <= 1'b0;
        end
        PREPARA: begin
          estado    <= ESPERA_NOTA;
          endereco  <= '0;
          duracao   <= '0;
          codigo    <= '0;
          parar_lat <= 1'b0;
        end
        ESPERA_NOTA: begin
          if (parar) begin
            estado     <= ESCREVE_FIM;
            mem_we_r   <= 1'b1;
            mem_dado_r <= '0;
          end else if (|teclas) begin
            estado  <= SEGURA;
            codigo  <= codigo_de(teclas);
            duracao <= DUR_W'(1);
          end
        end
        SEGURA: begin
          duracao <= dur_sat;
          if (!(|teclas) || parar) begin
            estado     <= GRAVA;
            mem_we_r   <= 1'b1;
            mem_dado_r <= {codigo, dur_sat};
            parar_lat  <= parar;
          end
        end
        GRAVA: begin
          estado   <= PROXIMO;
          endereco <= endereco + ADDR_W'(1);
        end
        PROXIMO: begin
          // Last address is kept for the marker, so reaching it ends the take.
          if (endereco == END_ULTIMO || parar_lat) begin
            estado     <= ESCREVE_FIM;
            mem_we_r   <= 1'b1;
            mem_dado_r <= '0;
            if (endereco == END_ULTIMO) memoria_cheia <= 1'b1;
          end else begin
            estado <= ESPERA_NOTA;
          end
        end
        ESCREVE_FIM: begin
          estado       <= FIM;
          gravando     <= 1'b0;
          fim_gravacao <= 1'b1;
        end
        FIM: if (iniciar_gravacao) begin
          estado        <= PREPARA;
          gravando      <= 1'b1;
          fim_gravacao  <= 1'b0;
          memoria_cheia <= 1'b0;
        end
        default: begin
          estado       <= OCIOSO;
          gravando     <= 1'b0;
          fim_gravacao <= 1'b0;
        end
      endcase
    end
  end

  assign mem.mem_endereco = endereco;
  assign mem.mem_dado     = mem_dado_r;
  assign mem.mem_we       = mem_we_r;
  assign db_estado        = estado;

endmodule

// File: tb/tb_gravador_notas.sv
// Scoreboard bench for gravador_notas: expected memory writes are queued as notes
// are played and matched against every mem_we cycle.
module tb_gravador_notas;

  logic        clock = 1'b0;
  logic        reset;
  logic        iniciar_gravacao;
  logic        parar;
  logic [11:0] teclas;
  logic        tick_metro;
  logic        gravando;
  logic        memoria_cheia;
  logic        fim_gravacao;
  logic [3:0]  db_estado;

  gravador_notas_if #(.ADDR_W(6), .DUR_W(4)) mbus ();

  gravador_notas #(.ADDR_W(6), .DUR_W(4), .TECLAS(12)) dut (
    .clock            (clock),
    .reset            (reset),
    .iniciar_gravacao (iniciar_gravacao),
    .parar            (parar),
    .teclas           (teclas),
    .tick_metro       (tick_metro),
    .mem              (mbus.master),
    .gravando         (gravando),
    .memoria_cheia    (memoria_cheia),
    .fim_gravacao     (fim_gravacao),
    .db_estado        (db_estado)
  );

  always #5 clock = ~clock;

  int          n_cmp = 0;
  int          n_err = 0;
  int          exp_addr = 0;
  logic [13:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every write strobe must match the oldest expected {addr, data}.
  always @(negedge clock) begin
    if (mbus.mem_we) begin
      if (exp_q.size() == 0) chk("we_extra", mbus.mem_we, 0);
      else chk("wr", {mbus.mem_endereco, mbus.mem_dado}, exp_q.pop_front());
    end
  end

  task automatic passo();
    @(posedge clock); #1;
  endtask

  task automatic inicia();
    iniciar_gravacao = 1'b1; passo(); iniciar_gravacao = 1'b0;
    chk("ini_gravando", gravando, 1);
    chk("ini_estado", db_estado, 1);
    chk("ini_cheia", memoria_cheia, 0);
    passo();
    chk("espera", db_estado, 2);
    exp_addr = 0;
  endtask

  task automatic push_marca();
    exp_q.push_back({6'(exp_addr), 8'h00});
  endtask

  // Plays one note from espera_nota: press (optional tick on the press cycle),
  // nt ticks, optional key change after the first tick, release (optional tick).
  task automatic nota(input logic [11:0] m, input logic [3:0] cod, input int nt,
                      input bit tp, input bit tr, input logic [11:0] m2);
    int d;
    teclas = m; tick_metro = tp; passo(); tick_metro = 1'b0;
    chk("segura", db_estado, 3);
    for (int i = 0; i < nt; i++) begin
      if (i == 1 && m2 != 12'h000) teclas = m2;
      tick_metro = 1'b1; passo(); tick_metro = 1'b0; passo();
    end
    d = 1 + nt + int'(tr);
    if (d > 15) d = 15;
    exp_q.push_back({6'(exp_addr), cod, 4'(d)});
    exp_addr++;
    if (exp_addr == 63) push_marca();
    teclas = 12'h000; tick_metro = tr; passo(); tick_metro = 1'b0;
    chk("grava_we", mbus.mem_we, 1);
    passo(); passo();
    if (exp_addr == 63) begin
      chk("cheia_estado", db_estado, 6);
      chk("cheia", memoria_cheia, 1);
    end else begin
      chk("volta_espera", db_estado, 2);
    end
  endtask

  task automatic para();
    parar = 1'b1; push_marca(); passo(); parar = 1'b0;
    chk("marca_estado", db_estado, 6);
    chk("marca_we", mbus.mem_we, 1);
    passo();
    chk("fim_estado", db_estado, 7);
    chk("fim_gravacao", fim_gravacao, 1);
    chk("fim_gravando", gravando, 0);
  endtask

  initial begin
    reset = 1'b1; iniciar_gravacao = 1'b0; parar = 1'b0;
    teclas = 12'h000; tick_metro = 1'b0;
    repeat (3) @(posedge clock); #1;
    chk("rst_estado", db_estado, 0);
    chk("rst_we", mbus.mem_we, 0);
    chk("rst_gravando", gravando, 0);
    chk("rst_fim", fim_gravacao, 0);
    chk("rst_addr", mbus.mem_endereco, 0);
    reset = 1'b0; passo();
    chk("ocioso", db_estado, 0);

    // key 0, three ticks, then stop -> {1,4} then marker
    inicia();
    nota(12'h001, 4'd1, 3, 0, 0, 12'h000);
    para();
    chk("nao_cheia", memoria_cheia, 0);

    // chord, key change mid-hold, press/release tick boundaries, saturation
    inicia();
    nota(12'h090, 4'd5, 0, 0, 0, 12'h000);
    nota(12'h090, 4'd5, 3, 0, 0, 12'h001);
    nota(12'h004, 4'd3, 2, 1, 1, 12'h000);
    nota(12'h200, 4'd10, 20, 0, 0, 12'h000);
    // stop while holding key 11: note first, marker next
    teclas = 12'h800; passo();
    tick_metro = 1'b1; passo(); tick_metro = 1'b0; passo();
    tick_metro = 1'b1; passo(); tick_metro = 1'b0; passo();
    parar = 1'b1;
    exp_q.push_back({6'(exp_addr), 4'd12, 4'd3});
    exp_addr++;
    passo(); parar = 1'b0; teclas = 12'h000;
    chk("parar_grava", mbus.mem_we, 1);
    passo();
    chk("parar_prox", db_estado, 5);
    push_marca();
    passo();
    chk("parar_marca", mbus.mem_we, 1);
    passo();
    chk("parar_fim", fim_gravacao, 1);

    // stop with a simultaneous press: marker only
    inicia();
    teclas = 12'h001; parar = 1'b1; push_marca();
    passo(); parar = 1'b0; teclas = 12'h000;
    chk("so_marca", db_estado, 6);
    passo();
    chk("so_marca_fim", db_estado, 7);

    // fill memory: 63 notes, marker at 63
    inicia();
    for (int i = 0; i < 63; i++)
      nota(12'(1 << (i % 12)), 4'((i % 12) + 1), 0, 0, 0, 12'h000);
    passo();
    chk("cheia_fim", fim_gravacao, 1);
    chk("cheia_mantida", memoria_cheia, 1);

    // reset in segura: nothing written, all outputs cleared
    inicia();
    teclas = 12'h001; passo();
    chk("rst_segura", db_estado, 3);
    tick_metro = 1'b1; passo(); tick_metro = 1'b0;
    #2 reset = 1'b1; #1;
    chk("rst2_estado", db_estado, 0);
    chk("rst2_gravando", gravando, 0);
    chk("rst2_we", mbus.mem_we, 0);
    chk("rst2_addr", mbus.mem_endereco, 0);
    teclas = 12'h000; passo(); passo();
    reset = 1'b0; passo();
    inicia();
    nota(12'h008, 4'd4, 1, 0, 0, 12'h000);
    para();

    repeat (3) passo();
    chk("fila_vazia", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gravador_notas.md
# gravador_notas

Note recorder for the FPGAudio piano: while recording is enabled, it captures the keys the player presses, measures how long each is held in metronome ticks, and writes one word per note into the song memory. It drives the song memory's write side. The mode control units drive the read side, and the recorded word format matches what they read back. An end-of-song marker word terminates every recording, so playback detects `fim_musica` the same way it does for stored songs.

## Interface
Parameters:
- `ADDR_W`, 6: song memory address width; the last address (2^ADDR_W−1) is reserved for the end marker.
- `DUR_W`, 4: duration field width in metronome ticks; saturates at 2^DUR_W−1.
- `TECLAS`, 12: number of piano keys (one-hot/multi-hot input).

Ports:
- `clock`, in, 1: single system clock; all logic on the rising edge.
- `reset`, in, 1: asynchronous, active-high; forces state `ocioso` and all outputs to 0.
- `iniciar_gravacao`, in, 1: level; sampled in `ocioso` and `fim` to start a new recording.
- `parar`, in, 1: level; requests end of recording.
- `teclas`, in, TECLAS: key levels, already synchronous to `clock` and debounced.
- `tick_metro`, in, 1: one-cycle pulse per metronome beat.
- `mem_endereco`, out, ADDR_W: write address.
- `mem_dado`, out, 4+DUR_W: {codigo_nota[3:0], duracao[DUR_W−1:0]}.
- `mem_we`, out, 1: write strobe, one cycle per word.
- `gravando`, out, 1: high in every state except `ocioso` and `fim`.
- `memoria_cheia`, out, 1: high from entry into `escreve_fim` caused by a full memory until the next start or reset.
- `fim_gravacao`, out, 1: high in `fim`.
- `db_estado`, out, 4: current state code.

## Operation
Note code is the lowest set index of `teclas` plus 1, giving 1..12. A code of 0 means no key. The end marker word is all zeros.

State machine (codes in parentheses):
- `ocioso` (0): `iniciar_gravacao` → `prepara`.
- `prepara` (1): zero the address, duration and latched code → `espera_nota`.
- `espera_nota` (2): `parar` → `escreve_fim`; otherwise any key → `segura`. Entering `segura` latches the code and sets duration to 1.
- `segura` (3): each `tick_metro` increments duration, saturating at 2^DUR_W−1. Key changes while any key stays pressed are ignored; the latched code is kept. `teclas`==0 or `parar` → `grava`.
- `grava` (4): `mem_we`=1 with {code, duration} at the current address → `proximo`.
- `proximo` (5): address+1. If the new address is 2^ADDR_W−1, set `memoria_cheia` → `escreve_fim`. Otherwise, if `parar` was latched during `segura`, → `escreve_fim`; otherwise → `espera_nota`.
- `escreve_fim` (6): `mem_we`=1 with the all-zero word at the current address → `fim`.
- `fim` (7): hold. `iniciar_gravacao` → `prepara`.

Undefined codes go to `ocioso`.

Boundary rules:
- A `tick_metro` in the same cycle as the press does not increment duration.
- A `tick_metro` in the release cycle does increment duration.
- `parar` and a press in the same `espera_nota` cycle: `parar` wins and no note is written.
- `parar` during `segura` writes the held note first, then the marker.
- Reset mid-recording discards the note in progress, generates no write, and leaves memory contents as written.

## Timing
- Outputs are registered/Moore. `mem_endereco` and `mem_dado` are stable during the whole `mem_we` cycle.
- Release detected in cycle n (in `segura`): `mem_we` rises in cycle n+1 (`grava`); `espera_nota` is reached in cycle n+3.
- Minimum spacing between two note writes is 4 cycles.
- `iniciar_gravacao` in `ocioso`: `gravando`=1 from the next cycle.
- Reset values: all outputs 0, `db_estado`=0.
- Maximum notes per recording is 2^ADDR_W−1; the marker always occupies the last written address.

## Test plan
- Start; press key 0, give 3 ticks, release; then `parar` → word at addr 0 = {1, 4}, word at addr 1 = 0x00, `fim_gravacao`=1.
- Keys 4 and 7 pressed together, no ticks, released → code 5, duration 1; a key change mid-hold does not alter the written code.
- Hold for 20 ticks with DUR_W=4 → duration written as 15.
- Record 63 notes with ADDR_W=6 → addresses 0..62 hold notes, addr 63 holds the marker, `memoria_cheia`=1.
- `parar` asserted while holding key 11 → {12, d} written, then the marker at the next address; `parar` with a simultaneous press in `espera_nota` → marker only.
- Assert `reset` in `segura` → no `mem_we`, all outputs 0, state 0; a restart overwrites from addr 0.
